// File: rtl/seq_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state codes and
// sizing helpers for the digit counter.
package seq_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Number of digit cycles per operation.
    function automatic int seq_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width; at least one bit so NDIG==1 still has a legal vector.
    function automatic int seq_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_sub_digit.sv
// Combinational DIGIT-bit borrow-chain subtractor: diff = a - b - bin.
module seq_sub_digit
    import seq_sub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    logic [DIGIT:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        // Full-subtractor cell: borrow when b plus incoming borrow exceeds a.
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign bout = br[DIGIT];

endmodule

// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, with a start/done handshake. One digit cell is time-multiplexed over
// the operand digits.
// Optional macro SEQ_SUB_FLAGS_EN adds the zero and ovf result flags.
module seq_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SEQ_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NDIG = seq_ndig(WIDTH, DIGIT);
    localparam int CW   = seq_cnt_w(NDIG);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_cfg
        $error("seq_subtractor: WIDTH must be a positive multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_d;
    logic             dig_bo;
    logic [WIDTH-1:0] diff_nxt;
    logic             last;
    int               base;

    assign base  = 32'(count) * DIGIT;
    assign last  = (32'(count) == NDIG - 1);
    assign busy  = (state == RUN);
    assign dig_a = a_q[base +: DIGIT];
    assign dig_b = b_q[base +: DIGIT];

    seq_sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .bin  (borrow),
        .diff (dig_d),
        .bout (dig_bo)
    );

    // Result with the current digit merged in; used for the diff write and
    // for the flags, which must see the completed value on the last digit.
    always_comb begin
        diff_nxt              = diff;
        diff_nxt[base +: DIGIT] = dig_d;
    end

    // FSM, operand capture, digit sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        count  <= '0;
                        diff   <= '0;
                        bout   <= 1'b0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here.
                    diff   <= diff_nxt;
                    borrow <= dig_bo;
                    count  <= count + 1'b1;
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        bout  <= dig_bo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_SUB_FLAGS_EN
    // Flags are captured alongside done and then held with the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == RUN && last) begin
            zero <= (diff_nxt == '0);
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor (WIDTH=16, DIGIT=4). Stimulus pushes the
// hand-computed result for every accepted operation; a monitor pops and
// compares on each done pulse, including latency and busy duration.
module tb_seq_subtractor;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             z;
        logic             v;
        int               c0;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SEQ_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;

    seq_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .bin   (bin_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SEQ_SUB_FLAGS_EN
        ,
        .zero  (zero),
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: on each done pulse, pop and compare. Latency is counted from the
    // accept edge to the edge that raises done (NDIG edges), so done is seen
    // high when sampled at the (NDIG+1)th edge after accept.
    initial begin
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("diff",    32'(diff), 32'(e.d));
                    chk("bout",    32'(bout), 32'(e.bo));
                    chk("latency", 32'(cyc - e.c0), 32'(NDIG));
                    chk("busy_len", 32'(busy_cnt), 32'(NDIG));
`ifdef SEQ_SUB_FLAGS_EN
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("ovf",  32'(ovf),  32'(e.v));
`endif
                end
            end
            if (busy) busy_cnt++;
            else      busy_cnt = 0;
        end
    end

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Single operation; optional start glitch with junk operands in RUN cycle 2.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bv_in,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic ez, input logic ev,
                          input bit glitch);
        exp_t e;
        @(negedge clk);
        start = 1'b1; a_i = av; b_i = bv; bin_i = bv_in;
        e.d = ed; e.bo = eb; e.z = ez; e.v = ev; e.c0 = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("clear_diff", 32'(diff), 32'd0);
        chk("busy_run",   32'(busy), 32'd1);
        if (glitch) begin
            @(negedge clk);
            start = 1'b1; a_i = 16'h1111; b_i = 16'h2222; bin_i = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done("op");
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        exp_t e;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;

        //       a         b         bin   diff      bout  zero  ovf
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op(16'h0001, 16'h0002, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start held through done; second op accepted in DONE.
        @(negedge clk);
        start = 1'b1; a_i = 16'hFFFF; b_i = 16'h0001; bin_i = 1'b1;
        e.d = 16'hFFFD; e.bo = 1'b0; e.z = 1'b0; e.v = 1'b0; e.c0 = cyc + 1;
        q.push_back(e);
        e.d = 16'h8000; e.bo = 1'b1; e.z = 1'b0; e.v = 1'b1; e.c0 = cyc + 1 + NDIG + 1;
        q.push_back(e);
        @(negedge clk);
        a_i = 16'h7FFF; b_i = 16'hFFFF; bin_i = 1'b0;
        wait_done("b2b_first");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_clear",     32'(diff), 32'd0);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset during RUN cycle 2 aborts the operation without a done pulse.
        start = 1'b1; a_i = 16'h4321; b_i = 16'h1234; bin_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(q.size()), 32'd0);
        run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
